pixel_packer: RTL and testbench

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/video_pkg.sv | 17 +
 rtl/axis_out_reg.sv | 46 ++++
 rtl/pixel_packer.sv | 139 +++++++++++++
 tb/tb_pixel_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types and widths for the pixel packing path.
//   phase_t : position of a pixel inside a 4-pixel / 3-word packing group
//   RGB_W   : width of one expanded RGB888 pixel
//   WORD_W  : width of one output stream word
package video_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  localparam int unsigned RGB_W  = 24;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_data/last/user as a new valid word
//   load_data/last/user   : word presented for capture
//   tready                : downstream ready
//   tdata/tlast/tuser     : registered word (held stable while stalled)
//   tvalid                : registered word is valid
//   slot_free             : a load this cycle will not overwrite a pending word
module axis_out_reg
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              load_user,
  input  logic              tready,
  output logic [WORD_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              tuser,
  output logic              slot_free
);

  assign slot_free = !tvalid || tready;

  // A load alongside an output transfer replaces the word with no bubble;
  // the caller only loads when slot_free is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
      tuser  <= load_user;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs greyscale pixels, expanded to RGB888, into 32-bit AXI4-Stream words:
// every 4 input pixels (12 bytes) become 3 output words, little-endian bytes.
//   out_stream_aclk, periph_resetn : clock, asynchronous active-low reset
//   in_valid/in_ready              : upstream pixel handshake
//   in_pixel, in_first, in_lastx   : pixel, frame start, end of line
//   out_stream_*                   : AXI4-Stream master (tkeep fixed all-ones)
//   err_align                      : sticky framing error (first/lastx misplaced)
module pixel_packer
  import video_pkg::*;
#(
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned X_SIZE   = 640
) (
  input  logic                out_stream_aclk,
  input  logic                periph_resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_BITS-1:0] in_pixel,
  input  logic                in_first,
  input  logic                in_lastx,
  output logic [WORD_W-1:0]   out_stream_tdata,
  output logic [3:0]          out_stream_tkeep,
  output logic                out_stream_tlast,
  output logic                out_stream_tuser,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready,
  output logic                err_align
);

  if ((X_SIZE % 4) != 0) begin : g_bad_x_size
    $error("pixel_packer: X_SIZE must be a multiple of 4");
  end

  logic [7:0] pix8;
  if (PIX_BITS >= 8) begin : g_pix_top
    assign pix8 = in_pixel[PIX_BITS-1 -: 8];
  end else begin : g_pix_pad
    assign pix8 = {in_pixel, {(8 - PIX_BITS){1'b0}}};
  end

  logic [RGB_W-1:0] rgb;
  assign rgb = {3{pix8}};

  phase_t             phase_q, phase_d, eff_phase;
  logic [RGB_W-1:0]   res_q, res_d;
  logic               first_q, first_d;
  logic               err_q, err_d;
  logic               xfer_in;
  logic               load;
  logic [WORD_W-1:0]  word;
  logic               word_last, word_user;
  logic               slot_free;

  // PH0 never produces a word, so it can accept even when the output is stalled.
  assign in_ready = (phase_q == PH0) || slot_free;
  assign xfer_in  = in_valid && in_ready;

  always_comb begin
    phase_d   = phase_q;
    res_d     = res_q;
    first_d   = first_q;
    err_d     = err_q;
    eff_phase = phase_q;
    load      = 1'b0;
    word      = '0;
    word_last = 1'b0;
    word_user = 1'b0;
    if (xfer_in) begin
      // A frame start always opens a new group, dropping any partial one.
      eff_phase = in_first ? PH0 : phase_q;
      if (in_first && (phase_q != PH0)) err_d = 1'b1;
      if (in_lastx && (eff_phase != PH3)) err_d = 1'b1;
      case (eff_phase)
        PH0: begin
          res_d   = rgb;
          first_d = in_first;
          phase_d = PH1;
        end
        PH1: begin
          load      = 1'b1;
          word      = {rgb[7:0], res_q};
          word_user = first_q;
          word_last = in_lastx;
          res_d     = {8'h00, rgb[23:8]};
          phase_d   = PH2;
        end
        PH2: begin
          load      = 1'b1;
          word      = {rgb[15:0], res_q[15:0]};
          word_last = in_lastx;
          res_d     = {16'h0000, rgb[23:16]};
          phase_d   = PH3;
        end
        PH3: begin
          load      = 1'b1;
          word      = {rgb, res_q[7:0]};
          word_last = in_lastx;
          phase_d   = PH0;
        end
        default: phase_d = PH0;
      endcase
      // End of line closes the group early.
      if (in_lastx) phase_d = PH0;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      phase_q <= PH0;
      res_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  axis_out_reg u_out_reg (
    .clk       (out_stream_aclk),
    .rst_n     (periph_resetn),
    .load      (load),
    .load_data (word),
    .load_last (word_last),
    .load_user (word_user),
    .tready    (out_stream_tready),
    .tdata     (out_stream_tdata),
    .tvalid    (out_stream_tvalid),
    .tlast     (out_stream_tlast),
    .tuser     (out_stream_tuser),
    .slot_free (slot_free)
  );

  assign out_stream_tkeep = '1;
  assign err_align        = err_q;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

  logic        clk = 1'b0;
  logic        periph_resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        in_first = 1'b0;
  logic        in_lastx = 1'b0;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready = 1'b1;
  logic        err_align;

  always #5 clk = ~clk;

  pixel_packer #(.PIX_BITS(8), .X_SIZE(640)) dut (
    .out_stream_aclk   (clk),
    .periph_resetn     (periph_resetn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pixel          (in_pixel),
    .in_first          (in_first),
    .in_lastx          (in_lastx),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .err_align         (err_align)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  pix;
    logic        first;
    logic        lastx;
    logic        trdy;
    logic        e_ir;
    logic        e_tv;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_user;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } word_t;

  vec_t  vecs[$];
  word_t expq[$];
  int    total = 0;
  int    bad = 0;
  int    words_seen = 0;
  int    user_cnt = 0;
  int    last_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [7:0] pix, input logic f, input logic l,
                     input logic r, input logic ir, input logic tv, input logic [31:0] d,
                     input logic el, input logic eu, input logic ee);
    vec_t v;
    v.vld = vld; v.pix = pix; v.first = f; v.lastx = l; v.trdy = r;
    v.e_ir = ir; v.e_tv = tv; v.e_data = d; v.e_last = el; v.e_user = eu; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      in_valid = vecs[i].vld;
      in_pixel = vecs[i].pix;
      in_first = vecs[i].first;
      in_lastx = vecs[i].lastx;
      out_stream_tready = vecs[i].trdy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_tvalid", i), 32'(out_stream_tvalid), 32'(vecs[i].e_tv));
      chk($sformatf("v%0d_err", i), 32'(err_align), 32'(vecs[i].e_err));
      if (vecs[i].e_tv) begin
        chk($sformatf("v%0d_tdata", i), out_stream_tdata, vecs[i].e_data);
        chk($sformatf("v%0d_tlast", i), 32'(out_stream_tlast), 32'(vecs[i].e_last));
        chk($sformatf("v%0d_tuser", i), 32'(out_stream_tuser), 32'(vecs[i].e_user));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_lastx = 1'b0;
  endtask

  // Called at the falling edge: scores a word that transfers on the next rising edge.
  task automatic check_out();
    word_t e;
    if (out_stream_tvalid && out_stream_tready) begin
      words_seen++;
      if (out_stream_tuser) user_cnt++;
      if (out_stream_tlast) last_cnt++;
      if (expq.size() == 0) begin
        chk("extra_word", out_stream_tdata, 32'h0);
        chk("extra_word_seen", 32'(1), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("word_data", out_stream_tdata, e.data);
        chk("word_last", 32'(out_stream_tlast), 32'(e.last));
        chk("word_user", 32'(out_stream_tuser), 32'(e.user));
      end
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input logic f, input logic l, input bit rnd);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel = p;
      in_first = f;
      in_lastx = l;
      out_stream_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      done = in_valid && in_ready;
      check_out();
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 500) begin
        chk("accept_timeout", 32'(0), 32'(1));
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_lastx = 1'b0;
  endtask

  // Reference: bytes of successive pixels laid end to end, 4 bytes per word, LSB first.
  task automatic send_line(input bit frame_start, input bit rnd);
    logic [7:0] px[640];
    logic [7:0] b[1920];
    word_t w;
    for (int i = 0; i < 640; i++) begin
      px[i] = rnd ? 8'($urandom) : 8'(i * 7 + 3);
      b[3*i] = px[i]; b[3*i+1] = px[i]; b[3*i+2] = px[i];
    end
    for (int k = 0; k < 480; k++) begin
      w.data = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      w.user = frame_start && (k == 0);
      w.last = (k == 479);
      expq.push_back(w);
    end
    for (int i = 0; i < 640; i++)
      send_pix(px[i], frame_start && (i == 0), i == 639, rnd);
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    while (expq.size() > 0 && guard < 5000) begin
      in_valid = 1'b0;
      out_stream_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check_out();
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_left", 32'(expq.size()), 32'(0));
    expq.delete();
  endtask

  task automatic reset_pulse();
    periph_resetn = 1'b0;
    @(posedge clk); #1;
    periph_resetn = 1'b1;
  endtask

  int n_main;

  initial begin
    // Basic packing of 0x10..0x40
    add(1, 8'h10, 1, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'h20, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'h30, 0, 0, 1,  1, 1, 32'h20101010, 0, 1, 0);
    add(1, 8'h40, 0, 1, 1,  1, 1, 32'h30302020, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  1, 1, 32'h40404030, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    // Downstream stall of 5 cycles in the middle of a group
    add(1, 8'h01, 0, 0, 0,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'h02, 0, 0, 0,  1, 0, 32'h0,        0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 8'h03, 0, 0, 0,  0, 1, 32'h02010101, 0, 0, 0);
    add(1, 8'h03, 0, 0, 1,  1, 1, 32'h02010101, 0, 0, 0);
    add(1, 8'h04, 0, 0, 1,  1, 1, 32'h03030202, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  1, 1, 32'h04040403, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    // End of line on the 2nd pixel of a group
    add(1, 8'hA1, 0, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'hA2, 0, 1, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'hB1, 0, 0, 1,  1, 1, 32'hA2A1A1A1, 1, 0, 1);
    add(1, 8'hB2, 0, 0, 1,  1, 0, 32'h0,        0, 0, 1);
    add(0, 8'h00, 0, 0, 1,  1, 1, 32'hB2B1B1B1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1,  1, 0, 32'h0,        0, 0, 1);
    n_main = vecs.size();
    // Frame start in the middle of a group (applied after a reset)
    add(1, 8'h11, 1, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'h22, 1, 0, 1,  1, 0, 32'h0,        0, 0, 0);
    add(1, 8'h33, 0, 0, 1,  1, 0, 32'h0,        0, 0, 1);
    add(0, 8'h00, 0, 0, 1,  1, 1, 32'h33222222, 0, 1, 1);
    add(0, 8'h00, 0, 0, 1,  1, 0, 32'h0,        0, 0, 1);

    #1 periph_resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(out_stream_tvalid), 32'(0));
    chk("rst_tdata", out_stream_tdata, 32'h0);
    chk("rst_tlast", 32'(out_stream_tlast), 32'(0));
    chk("rst_tuser", 32'(out_stream_tuser), 32'(0));
    chk("rst_err", 32'(err_align), 32'(0));
    chk("tkeep", 32'(out_stream_tkeep), 32'hF);
    @(posedge clk); #1;
    periph_resetn = 1'b1;

    run_vecs(0, n_main);

    // Reset while a word is stalled
    in_valid = 1'b1; in_pixel = 8'h01; out_stream_tready = 1'b0;
    @(posedge clk); #1;
    in_pixel = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_tvalid", 32'(out_stream_tvalid), 32'(1));
    chk("pre_rst_err", 32'(err_align), 32'(1));
    #2 periph_resetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(out_stream_tvalid), 32'(0));
    chk("mid_rst_tdata", out_stream_tdata, 32'h0);
    chk("mid_rst_err", 32'(err_align), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    periph_resetn = 1'b1;

    run_vecs(n_main, vecs.size());

    // Full line, no back-pressure
    reset_pulse();
    words_seen = 0; user_cnt = 0; last_cnt = 0;
    send_line(1, 0);
    drain(0);
    chk("line_words", 32'(words_seen), 32'(480));
    chk("line_tuser_cnt", 32'(user_cnt), 32'(1));
    chk("line_tlast_cnt", 32'(last_cnt), 32'(1));
    chk("line_err", 32'(err_align), 32'(0));

    // Two frames of two lines with random valid/ready
    words_seen = 0; user_cnt = 0; last_cnt = 0;
    for (int fr = 0; fr < 2; fr++)
      for (int ln = 0; ln < 2; ln++)
        send_line(ln == 0, 1);
    drain(1);
    chk("rand_words", 32'(words_seen), 32'(1920));
    chk("rand_tuser_cnt", 32'(user_cnt), 32'(2));
    chk("rand_tlast_cnt", 32'(last_cnt), 32'(4));
    chk("rand_err", 32'(err_align), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
